// File: rtl/vga_text_console_master_if.sv
// Character-stream input, Avalon-MM VRAM write bus and cursor status of the text console master.
// No logic or latency of its own; wires only.
// Backpressure: CHAR_READY toward the source, AVM_WAITREQUEST from the VRAM slave.
interface vga_text_console_master_if;
  logic        CHAR_VALID;
  logic        CHAR_READY;
  logic [7:0]  CHAR_DATA;
  logic [7:0]  CHAR_COLOR;
  logic [11:0] AVM_ADDR;
  logic        AVM_CS;
  logic        AVM_WRITE;
  logic        AVM_READ;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST;
  logic [6:0]  CURSOR_X;
  logic [4:0]  CURSOR_Y;
  logic        BUSY;

  // The console block itself: consumes characters, drives the Avalon bus.
  modport master (
    input  CHAR_VALID, CHAR_DATA, CHAR_COLOR, AVM_WAITREQUEST,
    output CHAR_READY, AVM_ADDR, AVM_CS, AVM_WRITE, AVM_READ, AVM_BYTE_EN,
           AVM_WRITEDATA, CURSOR_X, CURSOR_Y, BUSY
  );

  // The environment: character source plus VRAM slave.
  modport slave (
    output CHAR_VALID, CHAR_DATA, CHAR_COLOR, AVM_WAITREQUEST,
    input  CHAR_READY, AVM_ADDR, AVM_CS, AVM_WRITE, AVM_READ, AVM_BYTE_EN,
           AVM_WRITEDATA, CURSOR_X, CURSOR_Y, BUSY
  );
endinterface

// File: rtl/vga_text_console_master.sv
// Turns a CP437 byte stream into VRAM writes with a hardware cursor and LF/CR/BS/FF handling.
// Latency: printable char 2 cycles (accept, write); LF/CR/BS 1 cycle; FF clear 1 + COLS*ROWS/2 cycles.
// Backpressure: CHAR_READY only in IDLE; AVM_WAITREQUEST freezes WRITE/CLEAR with outputs held.
module vga_text_console_master #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30,
  parameter logic [11:0] VRAM_BASE = 12'h000
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  vga_text_console_master_if.master   bus
);

  localparam logic [6:0]  X_LAST   = 7'(COLS - 1);
  localparam logic [4:0]  Y_LAST   = 5'(ROWS - 1);
  localparam logic [10:0] CLR_LAST = 11'(COLS * ROWS / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t      r_state;
  logic [6:0]  r_x;
  logic [4:0]  r_y;
  logic [10:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_wr;
  logic [10:0] r_clr_cnt;

  logic        w_accept;
  logic        w_wait;
  logic [7:0]  w_code;
  logic [7:0]  w_color;
  logic [11:0] w_idx;
  logic [4:0]  w_y_next;

  assign w_accept = bus.CHAR_VALID && (r_state == IDLE);
  assign w_wait   = bus.AVM_WAITREQUEST;
  assign w_code   = bus.CHAR_DATA;
  assign w_color  = bus.CHAR_COLOR;

  // Linear cell index of the cursor; two cells share one 32-bit VRAM word.
  assign w_idx    = 12'(r_y) * 12'(COLS) + 12'(r_x);

  // Row advance wraps to the top: there is no scrolling.
  assign w_y_next = (r_y == Y_LAST) ? 5'd0 : r_y + 5'd1;

  // Control FSM: cursor, Avalon outputs and clear counter, all registered.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= IDLE;
      r_x       <= 7'd0;
      r_y       <= 5'd0;
      r_addr    <= 11'd0;
      r_be      <= 4'b0000;
      r_wdata   <= 32'd0;
      r_wr      <= 1'b0;
      r_clr_cnt <= 11'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (w_code)
              8'h0A: begin
                r_x <= 7'd0;
                r_y <= w_y_next;
              end
              8'h0D: begin
                r_x <= 7'd0;
              end
              8'h08: begin
                // Backspace crosses to the end of the previous row but stops at (0,0).
                if (r_x != 7'd0) begin
                  r_x <= r_x - 7'd1;
                end else if (r_y != 5'd0) begin
                  r_x <= X_LAST;
                  r_y <= r_y - 5'd1;
                end
              end
              8'h0C: begin
                // Form feed: home the cursor now, then blank the whole screen word by word.
                r_x       <= 7'd0;
                r_y       <= 5'd0;
                r_clr_cnt <= 11'd0;
                r_addr    <= VRAM_BASE[10:0];
                r_be      <= 4'b1111;
                r_wdata   <= {8'h20, w_color, 8'h20, w_color};
                r_wr      <= 1'b1;
                r_state   <= CLEAR;
              end
              default: begin
                // Data is replicated into both halves; byte enables pick the cell.
                r_addr  <= VRAM_BASE[10:0] + w_idx[11:1];
                r_be    <= w_idx[0] ? 4'b1100 : 4'b0011;
                r_wdata <= {w_code, w_color, w_code, w_color};
                r_wr    <= 1'b1;
                r_state <= WRITE;
              end
            endcase
          end
        end

        WRITE: begin
          if (!w_wait) begin
            r_wr    <= 1'b0;
            r_state <= IDLE;
            if (r_x == X_LAST) begin
              r_x <= 7'd0;
              r_y <= w_y_next;
            end else begin
              r_x <= r_x + 7'd1;
            end
          end
        end

        CLEAR: begin
          if (!w_wait) begin
            if (r_clr_cnt == CLR_LAST) begin
              r_wr    <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_clr_cnt <= r_clr_cnt + 11'd1;
              r_addr    <= r_addr + 11'd1;
            end
          end
        end

        default: begin
          r_wr    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.CHAR_READY    = (r_state == IDLE);
  assign bus.BUSY          = (r_state != IDLE);
  assign bus.AVM_CS        = r_wr;
  assign bus.AVM_WRITE     = r_wr;
  assign bus.AVM_READ      = 1'b0;
  // Bit 11 selects the palette registers, which this block never touches.
  assign bus.AVM_ADDR      = {1'b0, r_addr};
  assign bus.AVM_BYTE_EN   = r_be;
  assign bus.AVM_WRITEDATA = r_wdata;
  assign bus.CURSOR_X      = r_x;
  assign bus.CURSOR_Y      = r_y;

endmodule

// File: tb/tb_vga_text_console_master.sv
// Bench for the text console master: scoreboard of expected VRAM writes plus per-scenario checks.
// Runs free on a 50 MHz clock; every wait is bounded.
// Drives AVM_WAITREQUEST to exercise the stall path.
module tb_vga_text_console_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vga_text_console_master_if bus();

  vga_text_console_master #(
    .COLS(80),
    .ROWS(30),
    .VRAM_BASE(12'h000)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [11:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          nwrites = 0;
  int          mx = 0;
  int          my = 0;
  logic [11:0] last_addr = '0;
  logic [3:0]  last_be = '0;
  logic [31:0] last_data = '0;

  // Scoreboard: every accepted Avalon write is popped and compared in order.
  always @(negedge clk) begin
    if (rst_n && bus.AVM_CS && bus.AVM_WRITE && !bus.AVM_WAITREQUEST) begin
      nwrites++;
      last_addr = bus.AVM_ADDR;
      last_be   = bus.AVM_BYTE_EN;
      last_data = bus.AVM_WRITEDATA;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h be=%b data=%h, none expected",
                 bus.AVM_ADDR, bus.AVM_BYTE_EN, bus.AVM_WRITEDATA);
      end else begin
        mon_e = q.pop_front();
        if ({bus.AVM_READ, bus.AVM_ADDR, bus.AVM_BYTE_EN, bus.AVM_WRITEDATA} !== {1'b0, mon_e}) begin
          bad++;
          $display("FAIL write rd/addr/be/data got %b/%h/%b/%h want 0/%h/%b/%h",
                   bus.AVM_READ, bus.AVM_ADDR, bus.AVM_BYTE_EN, bus.AVM_WRITEDATA,
                   mon_e.a, mon_e.be, mon_e.d);
        end
      end
    end
  end

  // Reference model: cursor update on acceptance and the VRAM writes that must follow.
  task automatic model_accept(input logic [7:0] c, input logic [7:0] col);
    int idx;
    case (c)
      8'h0A: begin mx = 0; my = (my == 29) ? 0 : my + 1; end
      8'h0D: mx = 0;
      8'h08: begin
        if (mx != 0) mx = mx - 1;
        else if (my != 0) begin mx = 79; my = my - 1; end
      end
      8'h0C: begin
        mx = 0; my = 0;
        for (int n = 0; n < 1200; n++) q.push_back({12'(n), 4'b1111, 8'h20, col, 8'h20, col});
      end
      default: begin
        idx = my * 80 + mx;
        q.push_back({12'(idx >> 1), (idx[0] ? 4'b1100 : 4'b0011), c, col, c, col});
        if (mx == 79) begin mx = 0; my = (my == 29) ? 0 : my + 1; end
        else mx = mx + 1;
      end
    endcase
  endtask

  // Present one byte, wait (bounded) for acceptance, then drop valid just after the accept edge.
  task automatic send_byte(input logic [7:0] c, input logic [7:0] col);
    int n;
    n = 0;
    @(negedge clk);
    bus.CHAR_VALID = 1'b1;
    bus.CHAR_DATA  = c;
    bus.CHAR_COLOR = col;
    while (!bus.CHAR_READY && n < 3000) begin @(negedge clk); n++; end
    if (!bus.CHAR_READY) begin
      total++; bad++;
      $display("FAIL send_timeout ready=%b want 1", bus.CHAR_READY);
    end else begin
      model_accept(c, col);
    end
    @(posedge clk); #1;
    bus.CHAR_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.CHAR_READY && n < 3000) begin @(negedge clk); n++; end
    if (!bus.CHAR_READY) begin
      total++; bad++;
      $display("FAIL wait_idle_timeout ready=%b want 1", bus.CHAR_READY);
    end
  endtask

  task automatic test_reset();
    #15;
    total++;
    if ({bus.AVM_CS, bus.AVM_WRITE, bus.AVM_READ} !== 3'b000) begin
      bad++; $display("FAIL reset_in_cs_wr_rd got %b want 000", {bus.AVM_CS, bus.AVM_WRITE, bus.AVM_READ});
    end
    #10 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.CHAR_READY, bus.BUSY} !== 2'b10) begin
      bad++; $display("FAIL reset_ready_busy got %b want 10", {bus.CHAR_READY, bus.BUSY});
    end
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== 12'd0) begin
      bad++; $display("FAIL reset_cursor got (%0d,%0d) want (0,0)", bus.CURSOR_X, bus.CURSOR_Y);
    end
    total++;
    if ({bus.AVM_ADDR, bus.AVM_BYTE_EN, bus.AVM_WRITEDATA} !== 48'd0) begin
      bad++; $display("FAIL reset_bus got %h/%b/%h want 000/0000/00000000",
                      bus.AVM_ADDR, bus.AVM_BYTE_EN, bus.AVM_WRITEDATA);
    end
  endtask

  task automatic test_char_a();
    int nw, lowcnt, n;
    nw = nwrites; lowcnt = 0; n = 0;
    send_byte(8'h41, 8'h1F);
    @(negedge clk);
    while (!bus.CHAR_READY && n < 20) begin lowcnt++; @(negedge clk); n++; end
    total++;
    if (lowcnt !== 1) begin bad++; $display("FAIL char_a_ready_low got %0d cycles want 1", lowcnt); end
    total++;
    if ({last_addr, last_be, last_data} !== {12'h000, 4'b0011, 32'h411F411F} || nwrites - nw !== 1) begin
      bad++; $display("FAIL char_a_write got %h/%b/%h n=%0d want 000/0011/411f411f n=1",
                      last_addr, last_be, last_data, nwrites - nw);
    end
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'd1, 5'd0}) begin
      bad++; $display("FAIL char_a_cursor got (%0d,%0d) want (1,0)", bus.CURSOR_X, bus.CURSOR_Y);
    end
  endtask

  task automatic test_wrap();
    int nw;
    for (int i = 0; i < 78; i++) begin
      send_byte(8'(8'h61 + (i % 26)), 8'($urandom_range(0, 255)));
      wait_idle();
    end
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'd79, 5'd0}) begin
      bad++; $display("FAIL wrap_pre_cursor got (%0d,%0d) want (79,0)", bus.CURSOR_X, bus.CURSOR_Y);
    end
    send_byte(8'h42, 8'h20);
    wait_idle();
    total++;
    if ({last_addr, last_be, last_data} !== {12'h027, 4'b1100, 32'h42204220}) begin
      bad++; $display("FAIL wrap_b_write got %h/%b/%h want 027/1100/42204220", last_addr, last_be, last_data);
    end
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'd0, 5'd1}) begin
      bad++; $display("FAIL wrap_b_cursor got (%0d,%0d) want (0,1)", bus.CURSOR_X, bus.CURSOR_Y);
    end
    for (int i = 0; i < 28; i++) begin send_byte(8'h0A, 8'h00); wait_idle(); end
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'd0, 5'd29}) begin
      bad++; $display("FAIL lf_bottom_cursor got (%0d,%0d) want (0,29)", bus.CURSOR_X, bus.CURSOR_Y);
    end
    nw = nwrites;
    send_byte(8'h0A, 8'h00);
    wait_idle();
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'd0, 5'd0} || nwrites !== nw) begin
      bad++; $display("FAIL lf_wrap got (%0d,%0d) writes=%0d want (0,0) writes=0",
                      bus.CURSOR_X, bus.CURSOR_Y, nwrites - nw);
    end
  endtask

  task automatic test_clear();
    int nw, busycnt, n;
    nw = nwrites; busycnt = 0; n = 0;
    send_byte(8'h0C, 8'h07);
    @(negedge clk);
    total++;
    if ({bus.BUSY, bus.CURSOR_X, bus.CURSOR_Y} !== {1'b1, 7'd0, 5'd0}) begin
      bad++; $display("FAIL clear_first busy=%b cursor=(%0d,%0d) want busy=1 (0,0)",
                      bus.BUSY, bus.CURSOR_X, bus.CURSOR_Y);
    end
    while (bus.BUSY && n < 2000) begin busycnt++; @(negedge clk); n++; end
    // The acceptance cycle is still IDLE, so BUSY covers just the 1200 CLEAR cycles.
    total++;
    if (nwrites - nw !== 1200 || busycnt !== 1200) begin
      bad++; $display("FAIL clear_count writes=%0d busy=%0d want 1200/1200", nwrites - nw, busycnt);
    end
    total++;
    if ({last_addr, last_be, last_data} !== {12'h4AF, 4'b1111, 32'h20072007} || q.size() != 0) begin
      bad++; $display("FAIL clear_last got %h/%b/%h pending=%0d want 4af/1111/20072007 pending=0",
                      last_addr, last_be, last_data, q.size());
    end
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'd0, 5'd0}) begin
      bad++; $display("FAIL clear_cursor got (%0d,%0d) want (0,0)", bus.CURSOR_X, bus.CURSOR_Y);
    end
  endtask

  task automatic test_waitreq();
    int nw;
    exp_t e;
    nw = nwrites;
    bus.AVM_WAITREQUEST = 1'b1;
    send_byte(8'hC1, 8'h5A);
    e = q[q.size() - 1];
    bus.CHAR_VALID = 1'b1;
    bus.CHAR_DATA  = 8'h33;
    bus.CHAR_COLOR = 8'h11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({bus.CHAR_READY, bus.AVM_CS, bus.AVM_WRITE, bus.AVM_ADDR, bus.AVM_BYTE_EN, bus.AVM_WRITEDATA}
          !== {3'b011, e}) begin
        bad++; $display("FAIL stall_hold cyc=%0d rdy=%b wr=%b bus=%h/%b/%h want rdy=0 wr=1 %h/%b/%h",
                        i, bus.CHAR_READY, bus.AVM_WRITE, bus.AVM_ADDR, bus.AVM_BYTE_EN,
                        bus.AVM_WRITEDATA, e.a, e.be, e.d);
      end
      if (i == 4) begin
        @(posedge clk); #1;
        bus.CHAR_VALID      = 1'b0;
        bus.AVM_WAITREQUEST = 1'b0;
      end
    end
    wait_idle();
    total++;
    if (nwrites - nw !== 1 || last_data[31:24] !== 8'hC1 || q.size() != 0) begin
      bad++; $display("FAIL stall_result writes=%0d code=%h pending=%0d want 1/c1/0",
                      nwrites - nw, last_data[31:24], q.size());
    end
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'(mx), 5'(my)}) begin
      bad++; $display("FAIL stall_cursor got (%0d,%0d) want (%0d,%0d)", bus.CURSOR_X, bus.CURSOR_Y, mx, my);
    end
  endtask

  task automatic test_bs();
    int nw;
    send_byte(8'h0D, 8'h00); wait_idle();
    for (int i = 0; i < 3; i++) begin send_byte(8'h0A, 8'h00); wait_idle(); end
    for (int i = 0; i < 5; i++) begin send_byte(8'h2A, 8'h34); wait_idle(); end
    nw = nwrites;
    send_byte(8'h08, 8'h00); wait_idle();
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'd4, 5'd3}) begin
      bad++; $display("FAIL bs1 got (%0d,%0d) want (4,3)", bus.CURSOR_X, bus.CURSOR_Y);
    end
    send_byte(8'h08, 8'h00); wait_idle();
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'd3, 5'd3}) begin
      bad++; $display("FAIL bs2 got (%0d,%0d) want (3,3)", bus.CURSOR_X, bus.CURSOR_Y);
    end
    send_byte(8'h0D, 8'h00); wait_idle();
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'd0, 5'd3}) begin
      bad++; $display("FAIL cr got (%0d,%0d) want (0,3)", bus.CURSOR_X, bus.CURSOR_Y);
    end
    send_byte(8'h08, 8'h00); wait_idle();
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'd79, 5'd2}) begin
      bad++; $display("FAIL bs_row got (%0d,%0d) want (79,2)", bus.CURSOR_X, bus.CURSOR_Y);
    end
    for (int i = 0; i < 28; i++) begin send_byte(8'h0A, 8'h00); wait_idle(); end
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'd0, 5'd0}) begin
      bad++; $display("FAIL lf_home got (%0d,%0d) want (0,0)", bus.CURSOR_X, bus.CURSOR_Y);
    end
    send_byte(8'h08, 8'h00); wait_idle();
    total++;
    if ({bus.CURSOR_X, bus.CURSOR_Y} !== {7'd0, 5'd0} || nwrites !== nw) begin
      bad++; $display("FAIL bs_origin got (%0d,%0d) writes=%0d want (0,0) writes=0",
                      bus.CURSOR_X, bus.CURSOR_Y, nwrites - nw);
    end
  endtask

  task automatic test_reset_mid_clear();
    int nw, n;
    nw = nwrites; n = 0;
    send_byte(8'h0C, 8'h4E);
    while (nwrites - nw < 300 && n < 2000) begin @(negedge clk); n++; end
    total++;
    if (nwrites - nw !== 300) begin
      bad++; $display("FAIL midclr_reach writes=%0d want 300", nwrites - nw);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.AVM_CS, bus.AVM_WRITE} !== 2'b00) begin
      bad++; $display("FAIL midclr_abort cs/wr=%b want 00", {bus.AVM_CS, bus.AVM_WRITE});
    end
    q.delete();
    mx = 0; my = 0;
    nw = nwrites;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.CHAR_READY, bus.BUSY, bus.CURSOR_X, bus.CURSOR_Y} !== {2'b10, 7'd0, 5'd0}) begin
      bad++; $display("FAIL midclr_idle rdy/busy=%b cursor=(%0d,%0d) want 10 (0,0)",
                      {bus.CHAR_READY, bus.BUSY}, bus.CURSOR_X, bus.CURSOR_Y);
    end
    send_byte(8'h55, 8'h3C);
    wait_idle();
    total++;
    if (last_addr !== 12'h000 || nwrites - nw !== 1) begin
      bad++; $display("FAIL midclr_next addr=%h writes=%0d want 000/1", last_addr, nwrites - nw);
    end
  endtask

  initial begin
    bus.CHAR_VALID      = 1'b0;
    bus.CHAR_DATA       = 8'h00;
    bus.CHAR_COLOR      = 8'h00;
    bus.AVM_WAITREQUEST = 1'b0;
    test_reset();
    test_char_a();
    test_wrap();
    test_clear();
    test_waitreq();
    test_bs();
    test_reset_mid_clear();
    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
